// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: two-approach signal controller with all-red clearance and tick-counted dwells.
// Define TRAFFIC_PED_EN to compile in the pedestrian request latch and PED_WALK phase.
module traffic_intersection_ctrl #(
    parameter int GREEN_TICKS  = 30,
    parameter int YELLOW_TICKS = 5,
    parameter int ALLRED_TICKS = 2,
    parameter int PED_TICKS    = 10,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] ns_lights,
    output logic [2:0] ew_lights,
    output logic       ped_walk,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        ALL_RED   = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        PED_WALK  = 3'd5
    } state_t;

    localparam int MAX_A = GREEN_TICKS > YELLOW_TICKS ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_B = ALLRED_TICKS > PED_TICKS ? ALLRED_TICKS : PED_TICKS;
    localparam int MAX_T = MAX_A > MAX_B ? MAX_A : MAX_B;

    if (MAX_T - 1 >= (1 << CNT_W) || GREEN_TICKS < 1 || YELLOW_TICKS < 1 ||
        ALLRED_TICKS < 1 || PED_TICKS < 1) begin : g_bad_params
        $error("traffic_intersection_ctrl: durations must be >= 1 and fit in CNT_W bits");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_next_dir;
    logic [2:0]       r_ns;
    logic [2:0]       r_ew;
    state_t           w_next;
    state_t           w_green;
    logic             w_adv;
    logic             w_ped;
    logic [CNT_W-1:0] w_load;
    logic [2:0]       w_ns;
    logic [2:0]       w_ew;

`ifdef TRAFFIC_PED_EN
    logic r_ped_pending;
    logic r_ped_walk;
    assign w_ped    = r_ped_pending;
    assign ped_walk = r_ped_walk;
`else
    logic w_unused;
    assign w_ped    = 1'b0;
    assign ped_walk = 1'b0;
    assign w_unused = ped_req;
`endif

    // Unreachable codes fall through to ALL_RED on their next advance.
    always_comb begin
        w_adv   = tick && (r_cnt == '0);
        w_green = r_next_dir ? EW_GREEN : NS_GREEN;
        w_next  = (r_state == NS_GREEN)  ? NS_YELLOW :
                  (r_state == NS_YELLOW) ? ALL_RED :
                  (r_state == EW_GREEN)  ? EW_YELLOW :
                  (r_state == EW_YELLOW) ? ALL_RED :
                  (r_state == PED_WALK)  ? w_green :
                  (r_state == ALL_RED)   ? (w_ped ? PED_WALK : w_green) : ALL_RED;
        w_load  = (w_next == NS_GREEN || w_next == EW_GREEN)   ? CNT_W'(GREEN_TICKS - 1) :
                  (w_next == NS_YELLOW || w_next == EW_YELLOW) ? CNT_W'(YELLOW_TICKS - 1) :
                  (w_next == PED_WALK)                         ? CNT_W'(PED_TICKS - 1) :
                                                                 CNT_W'(ALLRED_TICKS - 1);
        w_ns    = (w_next == NS_GREEN) ? 3'b001 : (w_next == NS_YELLOW) ? 3'b010 : 3'b100;
        w_ew    = (w_next == EW_GREEN) ? 3'b001 : (w_next == EW_YELLOW) ? 3'b010 : 3'b100;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ALL_RED;
            r_cnt      <= CNT_W'(ALLRED_TICKS - 1);
            r_next_dir <= 1'b0;
            r_ns       <= 3'b100;
            r_ew       <= 3'b100;
`ifdef TRAFFIC_PED_EN
            r_ped_pending <= 1'b0;
            r_ped_walk    <= 1'b0;
`endif
        end else begin
            if (w_adv) begin
                r_state    <= w_next;
                r_cnt      <= w_load;
                r_ns       <= w_ns;
                r_ew       <= w_ew;
                r_next_dir <= (w_next == NS_YELLOW) ? 1'b1 : (w_next == EW_YELLOW) ? 1'b0 : r_next_dir;
`ifdef TRAFFIC_PED_EN
                r_ped_walk <= (w_next == PED_WALK);
`endif
            end else if (tick) begin
                r_cnt <= r_cnt - 1'b1;
            end
`ifdef TRAFFIC_PED_EN
            // Entering the walk consumes the request, including one arriving on that same edge.
            r_ped_pending <= (w_adv && w_next == PED_WALK) ? 1'b0 : (r_ped_pending | ped_req);
`endif
        end
    end

    assign ns_lights = r_ns;
    assign ew_lights = r_ew;
    assign phase     = r_state;
endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb_traffic_intersection_ctrl: directed vector bench for traffic_intersection_ctrl (GREEN=4, YELLOW=2, ALLRED=1, PED=3).
module tb_traffic_intersection_ctrl;
    logic       clk;
    logic       reset;
    logic       tick;
    logic       ped_req;
    logic [2:0] ns_lights;
    logic [2:0] ew_lights;
    logic       ped_walk;
    logic [2:0] phase;

    int checks = 0;
    int fails  = 0;
    int vi     = 0;

    typedef struct {
        logic       rs;
        logic       tk;
        logic       rq;
        logic [2:0] ph;
    } vec_t;

    vec_t vq[$];

    localparam logic [2:0] S1 [15] = '{1,1,1,1,2,2,0,3,3,3,3,4,4,0,1};
`ifdef TRAFFIC_PED_EN
    localparam int N2 = 18;
    localparam int N4 = 38;
    localparam logic [2:0] S2 [N2] = '{1,1,1,1,2,2,0,5,5,5,3,3,3,3,4,4,0,1};
    localparam logic [2:0] S4 [N4] = '{1,1,1,1,2,2,0,5,5,5,3,3,3,3,4,4,0,5,5,5,
                                       1,1,1,1,2,2,0,5,5,5,3,3,3,3,4,4,0,1};
    localparam logic [2:0] PH32 = 3'd5;
`else
    localparam int N2 = 14;
    localparam int N4 = 29;
    localparam logic [2:0] S2 [N2] = '{1,1,1,1,2,2,0,3,3,3,3,4,4,0};
    localparam logic [2:0] S4 [N4] = '{1,1,1,1,2,2,0,3,3,3,3,4,4,0,
                                       1,1,1,1,2,2,0,3,3,3,3,4,4,0,1};
    localparam logic [2:0] PH32 = 3'd3;
`endif

    traffic_intersection_ctrl #(
        .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .PED_TICKS(3), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
        .ns_lights(ns_lights), .ew_lights(ew_lights), .ped_walk(ped_walk), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (vector %0d): got %b, expected %b", nm, vi, act, exp);
        end
    endtask

    task automatic chk_outputs(input logic [2:0] ph);
        chk("phase", phase, ph);
        chk("ns_lights", ns_lights, ph == 3'd1 ? 3'b001 : ph == 3'd2 ? 3'b010 : 3'b100);
        chk("ew_lights", ew_lights, ph == 3'd3 ? 3'b001 : ph == 3'd4 ? 3'b010 : 3'b100);
        chk("ped_walk", {2'b00, ped_walk}, {2'b00, ph == 3'd5});
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        tick    = 1'b0;
        ped_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_outputs(3'd0);
    endtask

    task automatic apply(input vec_t v);
        if (v.rs) do_reset();
        tick    = v.tk;
        ped_req = v.rq;
        @(posedge clk);
        #1;
        chk_outputs(v.ph);
    endtask

    task automatic add(input logic rs, input logic tk, input logic rq, input logic [2:0] ph);
        vq.push_back('{rs: rs, tk: tk, rq: rq, ph: ph});
    endtask

    // Both heads must never be non-red together.
    always @(negedge clk) begin
        checks++;
        if (ns_lights != 3'b100 && ew_lights != 3'b100) begin
            fails++;
            $display("FAIL safety: ns_lights=%b ew_lights=%b both non-red", ns_lights, ew_lights);
        end
    end

    initial begin
        reset   = 1'b1;
        tick    = 1'b0;
        ped_req = 1'b0;
        #12;
        for (int e = 1; e <= 15; e++) add(e == 1, 1'b1, 1'b0, S1[e-1]);
        for (int e = 1; e <= N2; e++) add(e == 1, 1'b1, e == 2, S2[e-1]);
        for (int e = 1; e <= 35; e++)
            add(e == 1, (e % 4) == 0, e == 2,
                e < 4 ? 3'd0 : e < 20 ? 3'd1 : e < 28 ? 3'd2 : e < 32 ? 3'd0 : PH32);
        for (int e = 1; e <= N4; e++) add(e == 1, 1'b1, e <= 20, S4[e-1]);
        foreach (vq[i]) begin
            vi = i;
            apply(vq[i]);
        end
        vi = -1;
        do_reset();
        for (int e = 1; e <= 8; e++) apply('{rs: 1'b0, tk: 1'b1, rq: 1'b0, ph: S1[e-1]});
        apply('{rs: 1'b0, tk: 1'b1, rq: 1'b1, ph: 3'd3});
        #2;
        reset = 1'b1;
        #1;
        chk_outputs(3'd0);
        vi = -2;
        do_reset();
        for (int e = 1; e <= 15; e++) apply('{rs: 1'b0, tk: 1'b1, rq: 1'b0, ph: S1[e-1]});
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
